updown_step_pulser: RTL and testbench
=====================================

// Module: updown_step_pulser
// PURPOSE
//  Front end for the 4-bit up/down counter: turns two raw, asynchronous push-button inputs into
//  clean single-cycle incr/decr step pulses. Synchronises, prescales the sample rate, debounces,
//  edge-detects and arbitrates. Sits directly upstream of the counter; incr/decr drive it 1:1.
// PARAMETERS
//  DIV_WIDTH        16     prescaler counter width
//  DIV_COUNT        50000  clk cycles per sample_tick (1..2**DIV_WIDTH-1; 1 = tick every clk)
//  DEBOUNCE_SAMPLES 4      consecutive equal samples needed to change a stable level (2..15)
//  REPEAT_DELAY     250    sample ticks, held press -> first repeat (used only with AUTO_REPEAT_EN)
//  REPEAT_PERIOD    50     sample ticks between repeats (used only with AUTO_REPEAT_EN)
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  rst_n     in   1  reset, asynchronous assert, active-low
//  up_btn    in   1  raw up button, asynchronous to clk, active-high
//  dn_btn    in   1  raw down button, asynchronous to clk, active-high
//  incr      out  1  one-clk step-up pulse (registered)
//  decr      out  1  one-clk step-down pulse (registered)
//  up_level  out  1  debounced up level
//  dn_level  out  1  debounced down level
//  conflict  out  1  one-clk pulse: simultaneous up/down press discarded
// BEHAVIOUR
//  - Reset (rst_n=0): sync flops, prescaler, debounce counters, FSMs, all outputs -> 0.
//    Async assert; release is sampled on clk. Button held through reset = fresh press after debounce.
//  - Sync: 2-flop synchroniser per button; no other logic sees raw inputs.
//  - Prescaler: cnt 0..DIV_COUNT-1, wraps to 0; sample_tick=1 for one clk when cnt==DIV_COUNT-1.
//  - Per-channel FSM (updated only on sample_tick): LOW -> CHK_HI on sample 1; CHK_HI counts
//    equal samples, any 0 -> LOW (count cleared); DEBOUNCE_SAMPLES-th 1 -> HIGH, level=1.
//    HIGH -> CHK_LO on 0; CHK_LO symmetric, back to HIGH on any 1; DEBOUNCE_SAMPLES-th 0 -> LOW.
//    Glitches shorter than DEBOUNCE_SAMPLES ticks never change level.
//  - Press event = rising edge of level. incr/decr asserted the clk after level rises, one clk only.
//  - Arbitration: up and dn press events in the same clk -> neither pulse, conflict=1 for one clk.
//    Press on one channel while the other is HIGH -> pulse issued normally.
//  - Invariant: incr & decr never both 1. Release edges produce no pulse.
//  - Latency button->pulse: 2 clk (sync) + up to DIV_COUNT*DEBOUNCE_SAMPLES clk + 1 clk.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: in HIGH, a repeat counter counts sample ticks. It emits an extra pulse
//   REPEAT_DELAY ticks after the press, then every REPEAT_PERIOD ticks, while level stays 1.
//   Counter clears on leaving HIGH/CHK_LO. Repeats suppressed while both levels are 1 (no conflict pulse).
//   Same-clk repeat on both channels is impossible when both are held (they are suppressed).
//  AUTO_REPEAT_EN undefined: exactly one pulse per press; REPEAT_* ignored, no repeat logic built.
// STRUCTURE
//  - step_pulser_pkg: channel state enum (LOW, CHK_HI, HIGH, CHK_LO); the debounce-count width
//    localparam derived from DEBOUNCE_SAMPLES.
//  - Sub-module debounce_channel (sync + FSM + edge detect [+ repeat]), instantiated twice.
//  - Top holds the shared prescaler, arbitration and output registers.
// TESTING  (DIV_COUNT=4, DEBOUNCE_SAMPLES=3 unless noted)
//  1 rst_n=0 with buttons toggling -> incr=decr=conflict=0, levels=0; after release, prescaler ticks every 4 clk.
//  2 up_btn held 20 ticks -> up_level rises on 3rd high tick; exactly one incr, 1 clk after; decr stays 0.
//  3 up_btn high for 2 ticks, then low -> up_level stays 0, no incr.
//  4 up_btn and dn_btn rise same clk, held 10 ticks -> no incr/decr, one conflict pulse.
//  5 rst_n pulsed low after 2 high samples, button held -> all cleared; incr only after 3 fresh high ticks.
//  6 AUTO_REPEAT_EN, REPEAT_DELAY=5, REPEAT_PERIOD=2: up held 12 ticks past level rise T0
//    -> incr at T0, T0+5, T0+7, T0+9, T0+11 (5 pulses).

Source files
------------

// File: rtl/updown_step_pulser_pkg.sv
// Shared types and constants for the up/down step pulser front end.
// The channel FSM states live here together with the width of the debounce
// sample counter and a helper that maps a state to its debounced level.
package step_pulser_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } chan_state_t;

  // Largest supported DEBOUNCE_SAMPLES; the counter is sized to hold it.
  localparam int DB_MAX_SAMPLES = 15;
  localparam int DB_CNT_W       = $clog2(DB_MAX_SAMPLES + 1);

  // The debounced level is 1 while the channel is HIGH or checking a release.
  function automatic logic level_of(input chan_state_t s);
    return (s == HIGH) || (s == CHK_LO);
  endfunction

endpackage

// File: rtl/updown_step_pulser_channel.sv
// debounce_channel: one push-button path of the step pulser.
// Two-flop synchroniser, debounce FSM advanced on sample_tick, rising-edge
// press detection and, when AUTO_REPEAT_EN is defined, a hold-to-repeat
// generator. Without AUTO_REPEAT_EN the rpt output is tied low and no repeat
// logic exists.
module debounce_channel
  import step_pulser_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 4
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 250,
  parameter int REPEAT_PERIOD = 50
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic sample_tick,
  output logic level,
  output logic press,
  output logic rpt
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_SAMPLES - 1);
  localparam logic [DB_CNT_W-1:0] CNT_ONE  = DB_CNT_W'(1);

  logic                sync_p0;
  logic                sync_p1;
  chan_state_t         state;
  chan_state_t         state_nxt;
  logic [DB_CNT_W-1:0] cnt;
  logic [DB_CNT_W-1:0] cnt_nxt;
  logic                level_d;

  // Stage p0/p1: bring the raw button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce state and equal-sample counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Debounce next-state: a level change needs DEBOUNCE_SAMPLES equal samples
  // in a row; any opposite sample while checking falls back and clears the count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (sample_tick) begin
      unique case (state)
        LOW: begin
          if (sync_p1) begin
            state_nxt = CHK_HI;
            cnt_nxt   = CNT_ONE;
          end
        end
        CHK_HI: begin
          if (!sync_p1) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!sync_p1) begin
            state_nxt = CHK_LO;
            cnt_nxt   = CNT_ONE;
          end
        end
        CHK_LO: begin
          if (sync_p1) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign level = level_of(state);

  // Delayed level for rising-edge (press) detection; releases give no event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign press = level & ~level_d;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_periodic;
  logic             rpt_q;
  logic [RPT_W-1:0] rpt_last;

  // The first repeat waits REPEAT_DELAY ticks, later ones REPEAT_PERIOD ticks.
  assign rpt_last = rpt_periodic ? PERIOD_LAST : DELAY_LAST;

  // Repeat generator: counts ticks while the level stays 1 across the tick,
  // clears as soon as the channel drops back to LOW/CHK_HI. rpt_q is aligned
  // with press so both reach the output register with the same latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b0;
      rpt_q        <= 1'b0;
    end else begin
      rpt_q <= 1'b0;
      if (!level_of(state_nxt)) begin
        rpt_cnt      <= '0;
        rpt_periodic <= 1'b0;
      end else if (sample_tick && level) begin
        if (rpt_cnt == rpt_last) begin
          rpt_q        <= 1'b1;
          rpt_cnt      <= '0;
          rpt_periodic <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + RPT_ONE;
        end
      end
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/updown_step_pulser.sv
// updown_step_pulser: push-button front end for the 4-bit up/down counter.
// Shared sample-rate prescaler, two debounce channels, press arbitration and
// the registered incr/decr/conflict outputs.
// Optional feature: define AUTO_REPEAT_EN to build hold-to-repeat; without
// it every press yields exactly one pulse and REPEAT_* are unused.
module updown_step_pulser
  import step_pulser_pkg::*;
#(
  parameter int DIV_WIDTH        = 16,
  parameter int DIV_COUNT        = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int REPEAT_DELAY     = 250,
  parameter int REPEAT_PERIOD    = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic up_btn,
  input  logic dn_btn,
  output logic incr,
  output logic decr,
  output logic up_level,
  output logic dn_level,
  output logic conflict
);

  // Reject configurations the counters cannot represent.
  if (DIV_COUNT < 1 || DIV_COUNT >= (1 << DIV_WIDTH)) begin : g_bad_div
    $error("DIV_COUNT must be in 1..2**DIV_WIDTH-1");
  end
  if (DEBOUNCE_SAMPLES < 2 || DEBOUNCE_SAMPLES > DB_MAX_SAMPLES) begin : g_bad_db
    $error("DEBOUNCE_SAMPLES must be in 2..15");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
    $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_COUNT - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 sample_tick;
  logic                 up_press;
  logic                 dn_press;
  logic                 up_rpt;
  logic                 dn_rpt;
  logic                 both_high;
  logic                 up_ev;
  logic                 dn_ev;

  assign sample_tick = (div_cnt == DIV_LAST);

  // Prescaler: 0..DIV_COUNT-1, one sample_tick per wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (sample_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  debounce_channel #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
  ) u_up (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (up_btn),
    .sample_tick(sample_tick),
    .level      (up_level),
    .press      (up_press),
    .rpt        (up_rpt)
  );

  debounce_channel #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
  ) u_dn (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (dn_btn),
    .sample_tick(sample_tick),
    .level      (dn_level),
    .press      (dn_press),
    .rpt        (dn_rpt)
  );

  // Repeats are dropped while both buttons are held; presses always count.
  assign both_high = up_level & dn_level;
  assign up_ev     = up_press | (up_rpt & ~both_high);
  assign dn_ev     = dn_press | (dn_rpt & ~both_high);

  // Output stage: simultaneous events cancel each other and raise conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      incr     <= 1'b0;
      decr     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      incr     <= up_ev & ~dn_ev;
      decr     <= dn_ev & ~up_ev;
      conflict <= up_ev & dn_ev;
    end
  end

endmodule

// File: tb/tb_updown_step_pulser.sv
// Self-checking bench for updown_step_pulser (DIV_COUNT=4, DEBOUNCE_SAMPLES=3).
// Directed table of press/release phases, hand-written timing sequences, then
// random button activity compared each cycle with a run-length reference model.
module tb_updown_step_pulser;

  localparam int DIV = 4;
  localparam int DS  = 3;
  localparam int RD  = 5;
  localparam int RP  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic up_btn;
  logic dn_btn;
  logic incr;
  logic decr;
  logic up_level;
  logic dn_level;
  logic conflict;

  updown_step_pulser #(
    .DIV_WIDTH       (16),
    .DIV_COUNT       (DIV),
    .DEBOUNCE_SAMPLES(DS),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .up_btn  (up_btn),
    .dn_btn  (dn_btn),
    .incr    (incr),
    .decr    (decr),
    .up_level(up_level),
    .dn_level(dn_level),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int c_incr, c_decr, c_conf;
  bit seen_ul;
  bit chk_model = 1'b0;

  // Reference model state: synchroniser delay line, tick counter, per-channel
  // run length of samples disagreeing with the level, ticks held since press.
  int m_pcnt = 0;
  bit m_s1[2];
  bit m_s2[2];
  bit m_lvl[2];
  bit m_lvl_d[2];
  bit m_rpt[2];
  int m_run[2];
  int m_hold[2];
  bit m_incr, m_decr, m_conf;

  always @(posedge clk) begin
    bit ev[2];
    bit tick;
    bit both;
    bit old;
    if (!rst_n) begin
      m_pcnt = 0;
      m_incr = 0; m_decr = 0; m_conf = 0;
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_lvl_d[c] = 0;
        m_rpt[c] = 0; m_run[c] = 0; m_hold[c] = 0;
      end
    end else begin
      both = m_lvl[0] && m_lvl[1];
      for (int c = 0; c < 2; c++)
        ev[c] = (m_lvl[c] && !m_lvl_d[c]) || (m_rpt[c] && !both);
      m_incr = ev[0] && !ev[1];
      m_decr = ev[1] && !ev[0];
      m_conf = ev[0] && ev[1];
      tick = (m_pcnt == DIV - 1);
      for (int c = 0; c < 2; c++) begin
        m_lvl_d[c] = m_lvl[c];
        m_rpt[c]   = 0;
        if (tick) begin
          old = m_lvl[c];
          if (m_s2[c] != m_lvl[c]) m_run[c]++;
          else m_run[c] = 0;
          if (m_run[c] == DS) begin
            m_lvl[c] = !m_lvl[c];
            m_run[c] = 0;
          end
`ifdef AUTO_REPEAT_EN
          if (old && m_lvl[c]) begin
            m_hold[c]++;
            if (m_hold[c] == RD || (m_hold[c] > RD && (m_hold[c] - RD) % RP == 0))
              m_rpt[c] = 1;
          end else begin
            m_hold[c] = 0;
          end
`else
          if (!(old && m_lvl[c])) m_hold[c] = 0;
`endif
        end
      end
      m_pcnt = tick ? 0 : m_pcnt + 1;
      m_s2[0] = m_s1[0]; m_s1[0] = up_btn;
      m_s2[1] = m_s1[1]; m_s1[1] = dn_btn;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (incr === 1'b1)     c_incr++;
    if (decr === 1'b1)     c_decr++;
    if (conflict === 1'b1) c_conf++;
    if (up_level === 1'b1) seen_ul = 1'b1;
    if (chk_model)
      check("model", {27'b0, incr, decr, conflict, up_level, dn_level},
            {27'b0, m_incr, m_decr, m_conf, m_lvl[0], m_lvl[1]});
  endtask

  task automatic clr_counts();
    c_incr = 0; c_decr = 0; c_conf = 0; seen_ul = 1'b0;
  endtask

  typedef struct {
    string name;
    bit    up;
    bit    dn;
    int    n_incr;
    int    n_decr;
    int    n_conf;
    bit    ulvl;
    bit    dlvl;
  } row_t;

  row_t rows[$];

  initial begin
    int k, c0, lv, ip;
    int pulses[$];

    rst_n = 1'b0; up_btn = 1'b0; dn_btn = 1'b0;
    clr_counts();

    // Reset with buttons toggling: everything stays cleared.
    for (int i = 0; i < 8; i++) begin
      up_btn = 1'($urandom_range(0, 1));
      dn_btn = 1'($urandom_range(0, 1));
      step();
      check("reset_outputs", {27'b0, incr, decr, conflict, up_level, dn_level}, 32'd0);
    end
    up_btn = 1'b0; dn_btn = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("tick_period", {31'b0, dut.sample_tick}, {31'b0, (i % DIV) == DIV - 1});
    end

    // Press timing: level rises on the third high sample, incr one clk later.
    clr_counts();
    c0 = cyc; up_btn = 1'b1; k = 0;
    while (up_level !== 1'b1 && k < 40) begin step(); k++; end
    lv = cyc;
    check("press_level_latency_ok", {31'b0, (lv - c0 >= 11) && (lv - c0 <= 14)}, 32'd1);
    k = 0;
    while (incr !== 1'b1 && k < 6) begin step(); k++; end
    check("press_incr_after_level", cyc - lv, 32'd1);
    check("press_decr_quiet", c_decr, 32'd0);
    up_btn = 1'b0;
    repeat (40) step();

    // Two-tick glitch: never becomes a level, never a pulse.
    clr_counts();
    up_btn = 1'b1;
    repeat (8) step();
    up_btn = 1'b0;
    repeat (40) step();
    check("glitch_level", {31'b0, seen_ul}, 32'd0);
    check("glitch_incr", c_incr, 32'd0);

    // Reset after two high samples while held: debounce starts over.
    clr_counts();
    up_btn = 1'b1;
    repeat (10) step();
    check("mid_reset_pre_level", {31'b0, up_level}, 32'd0);
    rst_n = 1'b0;
    repeat (2) step();
    check("mid_reset_cleared", {27'b0, incr, decr, conflict, up_level, dn_level}, 32'd0);
    rst_n = 1'b1;
    clr_counts();
    repeat (8) step();
    check("mid_reset_two_ticks_level", {31'b0, up_level}, 32'd0);
    check("mid_reset_two_ticks_incr", c_incr, 32'd0);
    repeat (8) step();
    check("mid_reset_fresh_incr", c_incr, 32'd1);
    check("mid_reset_fresh_level", {31'b0, up_level}, 32'd1);
    up_btn = 1'b0;
    repeat (40) step();

`ifdef AUTO_REPEAT_EN
    // Held press with repeat: pulses at T0, T0+5, +7, +9, +11 ticks.
    clr_counts();
    up_btn = 1'b1; k = 0;
    while (incr !== 1'b1 && k < 60) begin step(); k++; end
    check("repeat_first_seen", {31'b0, incr}, 32'd1);
    ip = cyc;
    pulses.delete();
    for (int i = 1; i < 12 * DIV; i++) begin
      step();
      if (incr === 1'b1) pulses.push_back(cyc - ip);
    end
    check("repeat_count", pulses.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check("repeat_offset", (i < pulses.size()) ? pulses[i] : -1, DIV * (RD + RP * i));
    up_btn = 1'b0;
    repeat (60) step();
`endif

    // Table of five-tick phases: pulses counted per phase, levels at its end.
    rows.push_back('{"up_press",      1, 0, 1, 0, 0, 1, 0});
    rows.push_back('{"up_release",    0, 0, 0, 0, 0, 0, 0});
    rows.push_back('{"dn_press",      0, 1, 0, 1, 0, 0, 1});
`ifndef AUTO_REPEAT_EN
    rows.push_back('{"up_while_dn",   1, 1, 1, 0, 0, 1, 1});
`endif
    rows.push_back('{"all_release",   0, 0, 0, 0, 0, 0, 0});
    rows.push_back('{"both_same_clk", 1, 1, 0, 0, 1, 1, 1});
    rows.push_back('{"both_release",  0, 0, 0, 0, 0, 0, 0});
    rows.push_back('{"up_again",      1, 0, 1, 0, 0, 1, 0});
    rows.push_back('{"swap_to_dn",    0, 1, 0, 1, 0, 0, 1});
    rows.push_back('{"idle",          0, 0, 0, 0, 0, 0, 0});
    foreach (rows[i]) begin
      clr_counts();
      up_btn = rows[i].up;
      dn_btn = rows[i].dn;
      repeat (5 * DIV) step();
      check({rows[i].name, "_incr"},  c_incr, rows[i].n_incr);
      check({rows[i].name, "_decr"},  c_decr, rows[i].n_decr);
      check({rows[i].name, "_conf"},  c_conf, rows[i].n_conf);
      check({rows[i].name, "_uplvl"}, {31'b0, up_level}, {31'b0, rows[i].ulvl});
      check({rows[i].name, "_dnlvl"}, {31'b0, dn_level}, {31'b0, rows[i].dlvl});
    end

    // Random button activity against the reference model.
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    chk_model = 1'b1;
    c0 = cyc;
    while (cyc - c0 < 4000) begin
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
      end
      up_btn = 1'($urandom_range(0, 1));
      dn_btn = 1'($urandom_range(0, 1));
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(8, 70);
      repeat (k) step();
    end
    chk_model = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
